axis_channel_averager: RTL
==========================

Name: axis_channel_averager

Overview:
- Sits directly downstream of the AXIS data switch.
- Consumes 32-bit words carrying two signed 16-bit ADC channels: channel A in bits [15:0], channel B in bits [31:16].
- Averages each channel independently over 2^k consecutive accepted samples (boxcar decimation).
- Emits one 32-bit word per block to the downstream DDS/FIFO path, same channel packing.

Parameters:
- AXIS_TDATA_WIDTH, 32, input/output word width. Must be even; each half is one signed channel.
- LOG2_MAX_AVG, 8, maximum k. Accumulator width = AXIS_TDATA_WIDTH/2 + LOG2_MAX_AVG.

Ports:
- aclk  input  1  system clock.
- aresetn  input  1  asynchronous active-low reset.
- log2_avg  input  4  requested k. Values > LOG2_MAX_AVG are clamped to LOG2_MAX_AVG.
- S_AXIS_tdata  input  AXIS_TDATA_WIDTH  packed channel samples.
- S_AXIS_tvalid  input  1  slave valid.
- S_AXIS_tready  output  1  slave ready.
- M_AXIS_tready  input  1  master ready.
- M_AXIS_tdata  output  AXIS_TDATA_WIDTH  packed channel averages.
- M_AXIS_tvalid  output  1  master valid.

Behaviour:
- One clock (aclk); reset is asynchronous and active-low (aresetn).
- Reset values: M_AXIS_tvalid=0, M_AXIS_tdata=0, accumulators=0, sample counter=0, latched k=0.
- Reset mid-block discards the partial sums.
- Beat transfer: a slave beat is accepted when S_AXIS_tvalid && S_AXIS_tready. A master beat transfers when M_AXIS_tvalid && M_AXIS_tready.
- States (implicit in the counter):
  - IDLE/FIRST (cnt==0): on accept, latch k_l = clamp(log2_avg); accumulators load the sign-extended sample.
  - ACCUM (0<cnt<2^k_l-1): on accept, accumulators add the sign-extended sample; cnt++.
  - LAST (cnt==2^k_l-1): on accept, each result = (acc+sample)>>>k_l (arithmetic shift), truncated to 16 bits; M_AXIS_tdata registered; M_AXIS_tvalid=1; cnt=0.
- k_l=0: every accepted sample is simultaneously FIRST and LAST. The block becomes a registered pass-through with latency 1 cycle.
- log2_avg changes take effect only at the next block start. A change mid-block does not alter the current block.
- Latency: M_AXIS_tvalid rises on the cycle after the last sample of a block is accepted.
- S_AXIS_tready = !(cnt==2^k_l-1 && M_AXIS_tvalid && !M_AXIS_tready).
  - Non-final samples are always accepted.
  - A final sample stalls only while the output register holds an untaken result.
  - No combinational path from S_AXIS_tvalid to S_AXIS_tready.
- Output hold: M_AXIS_tvalid stays high and M_AXIS_tdata stays stable until M_AXIS_tready.
- Simultaneous output handshake and final-sample accept in the same cycle: the new result replaces the old one and M_AXIS_tvalid stays 1. No bubble, no loss.
- Full rate: with M_AXIS_tready held high, throughput is 1 input beat/cycle at every k.
- Arithmetic: channels never interact. The accumulator cannot overflow because its width is 16+LOG2_MAX_AVG. Results always lie in [-32768, 32767].

Optional Feature:
- Macro AXIS_CHANNEL_AVERAGER_ROUND_EN.
- Defined: for k_l>0, 2^(k_l-1) is added to each sum before the arithmetic shift (round half up). k_l=0 is unchanged.
- Undefined: plain arithmetic shift (floor toward -inf).
- Handshake and latency are identical in both builds.

Test Plan:
- Pass-through: log2_avg=0, M_AXIS_tready=1, inputs 0x0001_FFFF, 0x8000_7FFF.
  - Outputs are the same words, each 1 cycle after its accept.
- Basic average: log2_avg=2, inputs A={1,2,3,4}, B={-1,-2,-3,-4}.
  - Exactly one output word.
  - Without ROUND: A=2, B=-3, tdata 0xFFFD_0002.
  - With ROUND: A=3, B=-2, tdata 0xFFFE_0003.
- Extremes: log2_avg=8, 256 samples of 0x8000_7FFF.
  - Output 0x8000_7FFF; no overflow in either build.
- Backpressure: log2_avg=1, M_AXIS_tready=0 after the first result, continuous valid input.
  - Third sample accepted; fourth (final) sample stalled with S_AXIS_tready=0.
  - First result held stable until tready rises; no sample lost or duplicated.
- Mid-block k change and clamp: log2_avg changed 2->15 after 2 of 4 samples.
  - Current block closes after 4 samples.
  - Next block uses k=8 and closes after 256 samples.
- Async reset mid-block: aresetn pulsed low after 3 of 4 samples with M_AXIS_tvalid=1.
  - M_AXIS_tvalid drops immediately.
  - Next 4 samples {8,8,8,8} yield A=8, with no residue from before reset.

Source files
------------

// File: rtl/axis_channel_averager.sv
// axis_channel_averager
//
// Boxcar decimator for two packed signed ADC channels. Each accepted
// S_AXIS word carries channel A in the low half and channel B in the high
// half. Each channel is averaged on its own over 2^k consecutive accepted
// samples. One M_AXIS word with the same packing is emitted per block.
//
// Parameters:
//   AXIS_TDATA_WIDTH  word width (even; each half is one signed channel)
//   LOG2_MAX_AVG      largest usable k; accumulators are
//                     AXIS_TDATA_WIDTH/2 + LOG2_MAX_AVG bits wide
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   log2_avg          requested k, clamped to LOG2_MAX_AVG, sampled at block start
//   S_AXIS_*          sample input stream (tdata/tvalid/tready)
//   M_AXIS_*          average output stream (tdata/tvalid/tready)
//
// Build option:
//   AXIS_CHANNEL_AVERAGER_ROUND_EN  when defined, adds 2^(k-1) before the
//   shift (round half up) for k>0; otherwise the shift floors toward -inf.
module axis_channel_averager #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int LOG2_MAX_AVG     = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [3:0]                  log2_avg,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    input  logic                        M_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid
);

    localparam int         CH_W  = AXIS_TDATA_WIDTH / 2;
    localparam int         ACC_W = CH_W + LOG2_MAX_AVG;
    localparam int         CNT_W = LOG2_MAX_AVG;
    localparam logic [3:0] K_MAX = 4'(LOG2_MAX_AVG);

    logic [CNT_W-1:0]        cnt;
    logic [3:0]              k_l;
    logic signed [ACC_W-1:0] acc_a;
    logic signed [ACC_W-1:0] acc_b;

    logic [3:0]              k_req;
    logic [3:0]              k_eff;
    logic [CNT_W:0]          span;
    logic                    is_first;
    logic                    is_last;
    logic                    accept;
    logic signed [ACC_W-1:0] smp_a;
    logic signed [ACC_W-1:0] smp_b;
    logic signed [ACC_W-1:0] sum_a;
    logic signed [ACC_W-1:0] sum_b;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] avg_a;
    logic signed [ACC_W-1:0] avg_b;

    always_comb begin
        k_req    = (log2_avg > K_MAX) ? K_MAX : log2_avg;
        is_first = (cnt == '0);
        // At a block start the latched k is stale; the block length comes
        // from the request being latched on this very accept.
        k_eff    = is_first ? k_req : k_l;
        span     = (CNT_W+1)'(1) << k_eff;
        is_last  = ({1'b0, cnt} == (span - (CNT_W+1)'(1)));

        // Ready depends only on registered state, log2_avg and M_AXIS_tready.
        S_AXIS_tready = !(is_last && M_AXIS_tvalid && !M_AXIS_tready);
        accept        = S_AXIS_tvalid && S_AXIS_tready;

        smp_a = {{LOG2_MAX_AVG{S_AXIS_tdata[CH_W-1]}}, S_AXIS_tdata[CH_W-1:0]};
        smp_b = {{LOG2_MAX_AVG{S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}},
                 S_AXIS_tdata[AXIS_TDATA_WIDTH-1:CH_W]};
        sum_a = (is_first ? '0 : acc_a) + smp_a;
        sum_b = (is_first ? '0 : acc_b) + smp_b;

`ifdef AXIS_CHANNEL_AVERAGER_ROUND_EN
        rnd = (k_eff == 4'd0) ? '0 : (ACC_W'(1) << (k_eff - 4'd1));
`else
        rnd = '0;
`endif
        // Headroom of LOG2_MAX_AVG bits covers the sum plus the rounding term.
        avg_a = (sum_a + rnd) >>> k_eff;
        avg_b = (sum_b + rnd) >>> k_eff;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt           <= '0;
            k_l           <= '0;
            acc_a         <= '0;
            acc_b         <= '0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
        end else begin
            if (accept) begin
                if (is_first) begin
                    k_l <= k_eff;
                end
                if (is_last) begin
                    cnt          <= '0;
                    M_AXIS_tdata <= {CH_W'(avg_b), CH_W'(avg_a)};
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                    acc_a <= sum_a;
                    acc_b <= sum_b;
                end
            end
            // A new result overwrites one being taken this cycle: no bubble.
            if (accept && is_last) begin
                M_AXIS_tvalid <= 1'b1;
            end else if (M_AXIS_tready) begin
                M_AXIS_tvalid <= 1'b0;
            end
        end
    end

endmodule
